// File: rtl/deit_tile_scheduler.sv
// ============================================================================
// deit_tile_scheduler
//
// Sequences a tiled matrix job onto a systolic core. A job is M rows by
// K_TILES depth tiles by N_TILES output tiles. For every N tile the core is
// run once per K tile: the first pass overwrites the accumulator and later
// passes accumulate. After the last K pass the finished tile is held for
// downstream with tile_valid until tile_ack, then the next N tile starts.
//
// Optional feature macro: DEIT_SCHED_PERF_EN
//   When defined, two saturating 32-bit performance counters are added
//   (perf_core_cycles, perf_drain_cycles). When undefined they do not exist.
//
// Ports
//   clk                 : single clock, rising edge
//   rst                 : synchronous active-high reset
//   start               : one-cycle job launch (honoured only in IDLE)
//   abort               : drop the current job and return to IDLE
//   cfg_m_rows          : rows per pass (M), latched on start
//   cfg_k_tiles         : K tile count, latched on start
//   cfg_n_tiles         : N tile count, latched on start
//   core_start          : one-cycle pass launch to the core
//   core_compute_cycles : compute length for the pass (M)
//   core_acc_mode       : 0 = overwrite accumulator, 1 = accumulate
//   core_done           : pass completion pulse from the core
//   act_base_addr       : activation buffer base for the pass
//   wgt_base_addr       : weight buffer base for the pass
//   tile_valid          : a finished N tile sits in the accumulator
//   tile_n_idx          : index of that N tile
//   tile_ack            : downstream has drained the accumulator
//   busy                : high whenever the scheduler is not IDLE
//   done                : one-cycle job completion pulse
//   perf_core_cycles    : (DEIT_SCHED_PERF_EN) cycles spent in WAIT_CORE
//   perf_drain_cycles   : (DEIT_SCHED_PERF_EN) cycles spent in DRAIN
// ============================================================================
module deit_tile_scheduler #(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 8,
    parameter int TILE_K     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           cfg_m_rows,
    input  logic [CNT_WIDTH-1:0]  cfg_k_tiles,
    input  logic [CNT_WIDTH-1:0]  cfg_n_tiles,
    output logic                  core_start,
    output logic [31:0]           core_compute_cycles,
    output logic                  core_acc_mode,
    input  logic                  core_done,
    output logic [ADDR_WIDTH-1:0] act_base_addr,
    output logic [ADDR_WIDTH-1:0] wgt_base_addr,
    output logic                  tile_valid,
    output logic [CNT_WIDTH-1:0]  tile_n_idx,
    input  logic                  tile_ack,
    output logic                  busy,
    output logic                  done
`ifdef DEIT_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_core_cycles,
    output logic [31:0]           perf_drain_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_CORE = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    logic [31:0]          m_rows;
    logic [CNT_WIDTH-1:0] k_tiles;
    logic [CNT_WIDTH-1:0] n_tiles;
    logic [CNT_WIDTH-1:0] k_idx;
    logic [CNT_WIDTH-1:0] n_idx;

    // Activation base: each K tile occupies M rows of the input buffer.
    function automatic logic [ADDR_WIDTH-1:0] calc_act_addr(
        input logic [CNT_WIDTH-1:0] k,
        input logic [31:0]          m
    );
        return ADDR_WIDTH'(32'(k) * m);
    endfunction

    // Weight base: weights are stored N-major, TILE_K rows per K tile.
    function automatic logic [ADDR_WIDTH-1:0] calc_wgt_addr(
        input logic [CNT_WIDTH-1:0] n,
        input logic [CNT_WIDTH-1:0] kt,
        input logic [CNT_WIDTH-1:0] k
    );
        return ADDR_WIDTH'((32'(n) * 32'(kt) + 32'(k)) * 32'(TILE_K));
    endfunction

    // The state machine and all of its outputs live in one register block.
    // Pass outputs are loaded on the edge that enters LAUNCH, using the
    // indices the pass will run with, so they are stable for all of LAUNCH
    // and WAIT_CORE. core_start and done are registered one cycle behind
    // the state that requests them, which gives the two-cycle gap between
    // a core_done edge and the following core_start. Abort takes priority
    // over every other event and never lets done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            m_rows              <= '0;
            k_tiles             <= '0;
            n_tiles             <= '0;
            k_idx               <= '0;
            n_idx               <= '0;
            core_start          <= 1'b0;
            core_compute_cycles <= '0;
            core_acc_mode       <= 1'b0;
            act_base_addr       <= '0;
            wgt_base_addr       <= '0;
            tile_valid          <= 1'b0;
            tile_n_idx          <= '0;
            done                <= 1'b0;
        end else if (abort) begin
            state               <= IDLE;
            k_idx               <= '0;
            n_idx               <= '0;
            core_start          <= 1'b0;
            core_compute_cycles <= '0;
            core_acc_mode       <= 1'b0;
            act_base_addr       <= '0;
            wgt_base_addr       <= '0;
            tile_valid          <= 1'b0;
            tile_n_idx          <= '0;
            done                <= 1'b0;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_rows  <= cfg_m_rows;
                        k_tiles <= cfg_k_tiles;
                        n_tiles <= cfg_n_tiles;
                        k_idx   <= '0;
                        n_idx   <= '0;
                        if ((cfg_k_tiles == '0) || (cfg_n_tiles == '0)) begin
                            state <= DONE;
                        end else begin
                            state               <= LAUNCH;
                            core_compute_cycles <= cfg_m_rows;
                            core_acc_mode       <= 1'b0;
                            act_base_addr       <= '0;
                            wgt_base_addr       <= '0;
                        end
                    end
                end
                LAUNCH: begin
                    core_start <= 1'b1;
                    state      <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        if (k_idx < (k_tiles - CNT_ONE)) begin
                            k_idx               <= k_idx + CNT_ONE;
                            state               <= LAUNCH;
                            core_compute_cycles <= m_rows;
                            core_acc_mode       <= 1'b1;
                            act_base_addr       <= calc_act_addr(k_idx + CNT_ONE, m_rows);
                            wgt_base_addr       <= calc_wgt_addr(n_idx, k_tiles, k_idx + CNT_ONE);
                        end else begin
                            state      <= DRAIN;
                            tile_valid <= 1'b1;
                            tile_n_idx <= n_idx;
                        end
                    end
                end
                DRAIN: begin
                    if (tile_ack) begin
                        k_idx      <= '0;
                        tile_valid <= 1'b0;
                        tile_n_idx <= '0;
                        if (n_idx < (n_tiles - CNT_ONE)) begin
                            n_idx               <= n_idx + CNT_ONE;
                            state               <= LAUNCH;
                            core_compute_cycles <= m_rows;
                            core_acc_mode       <= 1'b0;
                            act_base_addr       <= '0;
                            wgt_base_addr       <= calc_wgt_addr(n_idx + CNT_ONE, k_tiles, '0);
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done                <= 1'b1;
                    state               <= IDLE;
                    core_compute_cycles <= '0;
                    core_acc_mode       <= 1'b0;
                    act_base_addr       <= '0;
                    wgt_base_addr       <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

`ifdef DEIT_SCHED_PERF_EN
    // Saturating occupancy counters. They restart only when a job is
    // actually accepted, so values from the previous job stay readable
    // while the scheduler sits in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_core_cycles  <= '0;
            perf_drain_cycles <= '0;
        end else if ((state == IDLE) && start && !abort) begin
            perf_core_cycles  <= '0;
            perf_drain_cycles <= '0;
        end else begin
            if ((state == WAIT_CORE) && (perf_core_cycles != '1)) begin
                perf_core_cycles <= perf_core_cycles + 32'd1;
            end
            if ((state == DRAIN) && (perf_drain_cycles != '1)) begin
                perf_drain_cycles <= perf_drain_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_deit_tile_scheduler.sv
// ============================================================================
// tb_deit_tile_scheduler
//
// Self-checking bench for deit_tile_scheduler. Expected pass descriptors are
// queued when a job is launched and popped by a monitor on every core_start.
// Each scenario task drives a job, plays the roles of the core and the
// downstream drain, and checks the handshake behaviour inline.
// ============================================================================
module tb_deit_tile_scheduler;

    localparam int AW = 16;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [31:0]   cfg_m_rows;
    logic [CW-1:0] cfg_k_tiles;
    logic [CW-1:0] cfg_n_tiles;
    logic          core_start;
    logic [31:0]   core_compute_cycles;
    logic          core_acc_mode;
    logic          core_done;
    logic [AW-1:0] act_base_addr;
    logic [AW-1:0] wgt_base_addr;
    logic          tile_valid;
    logic [CW-1:0] tile_n_idx;
    logic          tile_ack;
    logic          busy;
    logic          done;

    typedef struct {
        logic [31:0]   cc;
        logic          acc;
        logic [AW-1:0] act;
        logic [AW-1:0] wgt;
    } pass_t;

    pass_t exp_q[$];
    int    vectors;
    int    miscompares;
    int    core_start_count;

    deit_tile_scheduler #(
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW),
        .TILE_K    (12)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .cfg_m_rows         (cfg_m_rows),
        .cfg_k_tiles        (cfg_k_tiles),
        .cfg_n_tiles        (cfg_n_tiles),
        .core_start         (core_start),
        .core_compute_cycles(core_compute_cycles),
        .core_acc_mode      (core_acc_mode),
        .core_done          (core_done),
        .act_base_addr      (act_base_addr),
        .wgt_base_addr      (wgt_base_addr),
        .tile_valid         (tile_valid),
        .tile_n_idx         (tile_n_idx),
        .tile_ack           (tile_ack),
        .busy               (busy),
        .done               (done)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario stalls despite its own bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor: every core_start must match the oldest queued pass.
    always @(negedge clk) begin
        pass_t e;
        if (core_start === 1'b1) begin
            core_start_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_core_start: observed core_start=1, required no pass pending");
            end else begin
                e = exp_q.pop_front();
                vectors++;
                if (core_compute_cycles !== e.cc) begin
                    miscompares++;
                    $display("[TB] FAIL pass_compute_cycles: observed %0d, required %0d", core_compute_cycles, e.cc);
                end
                vectors++;
                if (core_acc_mode !== e.acc) begin
                    miscompares++;
                    $display("[TB] FAIL pass_acc_mode: observed %0b, required %0b", core_acc_mode, e.acc);
                end
                vectors++;
                if (act_base_addr !== e.act) begin
                    miscompares++;
                    $display("[TB] FAIL pass_act_base: observed %0d, required %0d", act_base_addr, e.act);
                end
                vectors++;
                if (wgt_base_addr !== e.wgt) begin
                    miscompares++;
                    $display("[TB] FAIL pass_wgt_base: observed %0d, required %0d", wgt_base_addr, e.wgt);
                end
            end
        end
    end

    // ---------------- stimulus helpers (no comparisons) ----------------

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [31:0] m, input int k, input int n);
        pass_t p;
        for (int ni = 0; ni < n; ni++) begin
            for (int ki = 0; ki < k; ki++) begin
                p.cc  = m;
                p.acc = (ki != 0);
                p.act = AW'(32'(ki) * m);
                p.wgt = AW'((ni * k + ki) * 12);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic launch(input logic [31:0] m, input logic [CW-1:0] k, input logic [CW-1:0] n);
        cfg_m_rows  = m;
        cfg_k_tiles = k;
        cfg_n_tiles = n;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic wait_core_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge where core_start was seen; answers after 'delay'.
    task automatic finish_pass(input int delay);
        @(posedge clk);
        #1;
        repeat (delay) step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
    endtask

    task automatic wait_tile(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tile_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack_tile();
        @(posedge clk);
        #1;
        tile_ack = 1'b1;
        step();
        tile_ack = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_core_start: observed %0b, required 0", core_start); end
        vectors++; if (core_compute_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_compute_cycles: observed %0d, required 0", core_compute_cycles); end
        vectors++; if (core_acc_mode !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_acc_mode: observed %0b, required 0", core_acc_mode); end
        vectors++; if (act_base_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_act_base: observed %0d, required 0", act_base_addr); end
        vectors++; if (wgt_base_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_wgt_base: observed %0d, required 0", wgt_base_addr); end
        vectors++; if (tile_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tile_valid: observed %0b, required 0", tile_valid); end
        vectors++; if (tile_n_idx !== '0) begin miscompares++; $display("[TB] FAIL reset_tile_n_idx: observed %0d, required 0", tile_n_idx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: observed %0b, required 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: observed %0b, required 0", done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_pass();
        bit ok;
        push_job(32, 1, 1);
        launch(32, 8'd1, 8'd1);
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_core_start: observed seen=%0b, required 1", ok); end
        finish_pass(3);
        wait_tile(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_tile_valid: observed seen=%0b, required 1", ok); end
        vectors++; if (tile_n_idx !== 8'd0) begin miscompares++; $display("[TB] FAIL single_tile_idx: observed %0d, required 0", tile_n_idx); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy_drain: observed %0b, required 1", busy); end
        ack_tile();
        wait_done(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL single_done: observed seen=%0b, required 1", ok); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy_at_done: observed %0b, required 0", busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL single_done_width: observed %0b, required 0", done); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL single_pending: observed %0d passes left, required 0", exp_q.size()); end
    endtask

    task automatic test_k_accum();
        bit ok;
        int c0;
        c0 = core_start_count;
        push_job(32, 3, 1);
        launch(32, 8'd3, 8'd1);
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL kacc_start0: observed seen=%0b, required 1", ok); end
        finish_pass(1);
        @(negedge clk);
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL kacc_overhead_gap: observed %0b, required 0", core_start); end
        @(negedge clk);
        vectors++; if (core_start !== 1'b1) begin miscompares++; $display("[TB] FAIL kacc_overhead_launch: observed %0b, required 1", core_start); end
        finish_pass(0);
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL kacc_start2: observed seen=%0b, required 1", ok); end
        finish_pass(2);
        wait_tile(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL kacc_tile_valid: observed seen=%0b, required 1", ok); end
        ack_tile();
        wait_done(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL kacc_done: observed seen=%0b, required 1", ok); end
        vectors++; if (core_start_count - c0 != 3) begin miscompares++; $display("[TB] FAIL kacc_pass_count: observed %0d, required 3", core_start_count - c0); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL kacc_pending: observed %0d passes left, required 0", exp_q.size()); end
    endtask

    task automatic test_multi_n();
        bit ok;
        int c0;
        push_job(20, 2, 2);
        launch(20, 8'd2, 8'd2);
        for (int p = 0; p < 2; p++) begin
            wait_core_start(ok);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL multi_n0_start%0d: observed seen=%0b, required 1", p, ok); end
            finish_pass(1);
        end
        wait_tile(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL multi_tile0_valid: observed seen=%0b, required 1", ok); end
        vectors++; if (tile_n_idx !== 8'd0) begin miscompares++; $display("[TB] FAIL multi_tile0_idx: observed %0d, required 0", tile_n_idx); end
        c0 = core_start_count;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            vectors++; if (tile_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL multi_drain_hold%0d: observed %0b, required 1", i, tile_valid); end
        end
        vectors++; if (core_start_count != c0) begin miscompares++; $display("[TB] FAIL multi_no_start_in_drain: observed %0d starts, required 0", core_start_count - c0); end
        ack_tile();
        for (int p = 0; p < 2; p++) begin
            wait_core_start(ok);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL multi_n1_start%0d: observed seen=%0b, required 1", p, ok); end
            finish_pass(0);
        end
        wait_tile(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL multi_tile1_valid: observed seen=%0b, required 1", ok); end
        vectors++; if (tile_n_idx !== 8'd1) begin miscompares++; $display("[TB] FAIL multi_tile1_idx: observed %0d, required 1", tile_n_idx); end
        ack_tile();
        wait_done(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL multi_done: observed seen=%0b, required 1", ok); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL multi_pending: observed %0d passes left, required 0", exp_q.size()); end
    endtask

    task automatic test_zero_config();
        bit ok;
        int c0;
        c0 = core_start_count;
        launch(32, 8'd0, 8'd4);
        @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_busy: observed %0b, required 1", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_early: observed %0b, required 0", done); end
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_done_pulse: observed %0b, required 1", done); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_done_width: observed %0b, required 0", done); end
        launch(32, 8'd3, 8'd0);
        wait_done(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_n_done: observed seen=%0b, required 1", ok); end
        vectors++; if (core_start_count != c0) begin miscompares++; $display("[TB] FAIL zero_no_core_start: observed %0d starts, required 0", core_start_count - c0); end
    endtask

    task automatic test_abort();
        bit ok;
        int seen;
        push_job(16, 2, 1);
        launch(16, 8'd2, 8'd2);
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_start0: observed seen=%0b, required 1", ok); end
        finish_pass(1);
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_start1: observed seen=%0b, required 1", ok); end
        @(posedge clk);
        #1;
        abort     = 1'b1;
        core_done = 1'b1;
        step();
        abort     = 1'b0;
        core_done = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: observed %0b, required 0", busy); end
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_core_start: observed %0b, required 0", core_start); end
        vectors++; if (tile_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_tile_valid: observed %0b, required 0", tile_valid); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) seen++;
            @(negedge clk);
        end
        vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL abort_no_done: observed %0d pulses, required 0", seen); end
        push_job(8, 1, 1);
        launch(8, 8'd1, 8'd1);
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_restart_start: observed seen=%0b, required 1", ok); end
        finish_pass(1);
        wait_tile(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_restart_tile: observed seen=%0b, required 1", ok); end
        ack_tile();
        wait_done(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_restart_done: observed seen=%0b, required 1", ok); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL abort_pending: observed %0d passes left, required 0", exp_q.size()); end
    endtask

    task automatic test_spurious();
        bit ok;
        int seen;
        core_done = 1'b1;
        tile_ack  = 1'b1;
        step();
        core_done = 1'b0;
        tile_ack  = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_idle_busy: observed %0b, required 0", busy); end
        vectors++; if (tile_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_idle_tile_valid: observed %0b, required 0", tile_valid); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_idle_done: observed %0b, required 0", done); end
        push_job(4, 2, 1);
        launch(4, 8'd2, 8'd1);
        cfg_m_rows  = 32'd99;
        cfg_k_tiles = 8'd5;
        cfg_n_tiles = 8'd7;
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_start0: observed seen=%0b, required 1", ok); end
        @(posedge clk);
        #1;
        tile_ack = 1'b1;
        start    = 1'b1;
        step();
        tile_ack = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        vectors++; if (tile_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL spur_ack_in_wait: observed tile_valid=%0b, required 0", tile_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_busy_hold: observed %0b, required 1", busy); end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_start1: observed seen=%0b, required 1", ok); end
        finish_pass(0);
        wait_tile(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_tile: observed seen=%0b, required 1", ok); end
        ack_tile();
        wait_done(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_done: observed seen=%0b, required 1", ok); end
        push_job(4, 1, 1);
        launch(4, 8'd1, 8'd1);
        wait_core_start(ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("[TB] FAIL spur_rst_start: observed seen=%0b, required 1", ok); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        @(negedge clk);
        vectors++; if ({core_start, core_acc_mode, tile_valid, busy, done} !== 5'b0) begin miscompares++; $display("[TB] FAIL spur_rst_flags: observed %05b, required 00000", {core_start, core_acc_mode, tile_valid, busy, done}); end
        vectors++; if (core_compute_cycles !== 32'd0) begin miscompares++; $display("[TB] FAIL spur_rst_compute: observed %0d, required 0", core_compute_cycles); end
        vectors++; if ({act_base_addr, wgt_base_addr, tile_n_idx} !== '0) begin miscompares++; $display("[TB] FAIL spur_rst_addr: observed act=%0d wgt=%0d idx=%0d, required 0", act_base_addr, wgt_base_addr, tile_n_idx); end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("[TB] FAIL spur_rst_no_done: observed %0d pulses, required 0", seen); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL spur_pending: observed %0d passes left, required 0", exp_q.size()); end
    endtask

    // Scenario sequence.
    initial begin
        vectors          = 0;
        miscompares      = 0;
        core_start_count = 0;
        rst              = 1'b1;
        start            = 1'b0;
        abort            = 1'b0;
        core_done        = 1'b0;
        tile_ack         = 1'b0;
        cfg_m_rows       = '0;
        cfg_k_tiles      = '0;
        cfg_n_tiles      = '0;
        $display("[TB] starting deit_tile_scheduler bench");
        test_reset();
        test_single_pass();
        test_k_accum();
        test_multi_n();
        test_zero_config();
        test_abort();
        test_spurious();
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deit_tile_scheduler.md
DEIT_TILE_SCHEDULER -- requirements
Module: deit_tile_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning the width of the buffer base address outputs.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the tile counts and indices.
REQ-003 SHALL have parameter TILE_K, default 12, meaning the K depth per pass; it equals the array row count.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: single-cycle job launch request.
REQ-007 Port abort, input, 1 bit: terminates the job in progress.
REQ-008 Port cfg_m_rows, input, 32 bits: rows per pass (M).
REQ-009 Port cfg_k_tiles, input, CNT_WIDTH bits: number of K tiles.
REQ-010 Port cfg_n_tiles, input, CNT_WIDTH bits: number of N tiles.
REQ-011 Port core_start, output, 1 bit: pass launch pulse to the core (drives ap_start).
REQ-012 Port core_compute_cycles, output, 32 bits: drives the core's cfg_compute_cycles.
REQ-013 Port core_acc_mode, output, 1 bit: 0 overwrites the accumulator, 1 accumulates.
REQ-014 Port core_done, input, 1 bit: pass-complete pulse from the core (ap_done).
REQ-015 Port act_base_addr, output, ADDR_WIDTH bits: input buffer base address for the current pass.
REQ-016 Port wgt_base_addr, output, ADDR_WIDTH bits: weight buffer base address for the current pass.
REQ-017 Port tile_valid, output, 1 bit: an N tile result is ready in the accumulator.
REQ-018 Port tile_n_idx, output, CNT_WIDTH bits: index of that N tile.
REQ-019 Port tile_ack, input, 1 bit: downstream has drained the accumulator.
REQ-020 Port busy, output, 1 bit: high in every state except IDLE.
REQ-021 Port done, output, 1 bit: single-cycle job completion pulse.

Function
REQ-022 States SHALL be IDLE, LAUNCH, WAIT_CORE, DRAIN and DONE, encoded in one state register.
REQ-023 IDLE with start=1 SHALL latch all cfg_* inputs, clear n_idx and k_idx, and go to LAUNCH; if the latched cfg_k_tiles=0 or cfg_n_tiles=0 it SHALL go to DONE instead.
REQ-024 LAUNCH SHALL assert core_start for exactly one cycle, then go to WAIT_CORE.
REQ-025 While in LAUNCH and WAIT_CORE, the pass outputs SHALL be:
- core_compute_cycles = latched M;
- core_acc_mode = (k_idx != 0);
- act_base_addr = k_idx*M;
- wgt_base_addr = (n_idx*K_TILES + k_idx)*TILE_K.
Both addresses are truncated to ADDR_WIDTH.
REQ-026 WAIT_CORE with core_done=1 SHALL advance as follows:
- k_idx < K_TILES-1: increment k_idx and go to LAUNCH;
- otherwise: go to DRAIN.
REQ-027 DRAIN SHALL hold tile_valid=1 and tile_n_idx=n_idx until tile_ack=1 is sampled.
REQ-028 On the tile_ack=1 cycle in DRAIN, the block SHALL clear k_idx, then:
- if n_idx < N_TILES-1: increment n_idx and go to LAUNCH;
- otherwise: go to DONE.
REQ-029 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-030 start outside IDLE SHALL be ignored; core_done outside WAIT_CORE SHALL be ignored; tile_ack outside DRAIN SHALL be ignored.
REQ-031 abort=1 in any state SHALL return the block to IDLE on the next edge and deassert core_start and tile_valid; done SHALL NOT pulse; abort has priority over start, core_done and tile_ack in the same cycle.
REQ-032 Changes to cfg_* inputs after job launch SHALL have no effect until the next start.
REQ-033 Minimum pass overhead SHALL be 2 cycles: from the core_done edge to the next core_start.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL enter IDLE and clear all counters.
REQ-035 During reset, every output SHALL be 0: core_start, core_compute_cycles, core_acc_mode, act_base_addr, wgt_base_addr, tile_valid, tile_n_idx, busy and done.
REQ-036 Reset asserted mid-job SHALL behave as abort, with done not pulsed.

Configuration
REQ-037 Macro DEIT_SCHED_PERF_EN SHALL control performance counters:
- defined: adds 32-bit output perf_core_cycles, counting cycles in WAIT_CORE, and 32-bit output perf_drain_cycles, counting cycles in DRAIN; both clear on start accepted and on reset, and saturate at all ones;
- undefined: neither port nor counter logic exists.

Verification
REQ-038 Single pass (M=32, K=1, N=1): start -> one core_start with compute_cycles=32 and acc_mode=0; after core_done, tile_valid=1 with tile_n_idx=0; tile_ack -> done pulse.
REQ-039 K accumulation (M=32, K=3, N=1): exactly 3 core_start pulses, acc_mode sequence 0,1,1, act_base sequence 0,32,64, wgt_base sequence 0,12,24.
REQ-040 Multiple N tiles (K=2, N=2): wgt_base sequence 0,12,24,36; tile_valid stays high for 5 cycles while tile_ack is delayed, and no core_start is issued before tile_ack.
REQ-041 Zero config (K=0): start -> done pulse 2 cycles later with no core_start.
REQ-042 Abort in WAIT_CORE on the second pass -> IDLE next cycle, busy=0, no done; a fresh start then completes normally.
REQ-043 Spurious events: core_done in IDLE, tile_ack in WAIT_CORE, and start while busy produce no state change; a mid-job rst=1 yields all outputs 0.
